generatore_vga: RTL and testbench
=================================

# generatore_vga

Raster timing generator for the display pipeline. Produces the current-pixel coordinates `X_CONTROLLO`/`Y_CONTROLLO` consumed by the shape detectors (triangle, rectangle, …), plus horizontal/vertical sync, the visible-area flag, and a frame-start pulse. Sits directly upstream of every shape detector and of the colour mux. Default timing is 800x600@60 Hz with a 40 MHz pixel rate.

## Interface
Parameters:
- `H_ATTIVO`, 800, visible pixels per line
- `H_FRONT`, 40, horizontal front porch
- `H_SYNC`, 128, horizontal sync width
- `H_BACK`, 88, horizontal back porch
- `V_ATTIVO`, 600, visible lines
- `V_FRONT`, 1, vertical front porch
- `V_SYNC`, 4, vertical sync width
- `V_BACK`, 23, vertical back porch
- `SYNC_POL`, 1, active level of both syncs (1 = active-high)

Ports (one clock; reset is asynchronous and active-low):
- `CLK` in 1: pixel clock
- `RST_N` in 1: asynchronous active-low reset
- `PIXEL_EN` in 1: advance enable; counters move only when high
- `X_CONTROLLO` out 11: current column, 0..H_TOT-1
- `Y_CONTROLLO` out 11: current line, 0..V_TOT-1
- `H_SYNC` out 1: horizontal sync
- `V_SYNC` out 1: vertical sync
- `VISIBILE` out 1: high when X < H_ATTIVO and Y < V_ATTIVO
- `INIZIO_QUADRO` out 1: one-cycle frame-start pulse
- `QUADRO` out 8: frame counter (only with `GENERATORE_VGA_QUADRO_EN`)

## Operation
- H_TOT = sum of the four H parameters (1056 by default). V_TOT = sum of the four V parameters (628 by default).
- Both counters are 11 bits. Elaboration fails if H_TOT or V_TOT exceeds 2048.
- On each CLK edge with `PIXEL_EN=1`:
  - X increments.
  - At X = H_TOT-1, X wraps to 0 and Y increments.
  - At Y = V_TOT-1 with the X wrap, Y also wraps to 0.
- With `PIXEL_EN=0`, all outputs hold. `INIZIO_QUADRO` drops to 0.
- `H_SYNC` is active for H_ATTIVO+H_FRONT ≤ X < H_ATTIVO+H_FRONT+H_SYNC (840..967 by default).
- `V_SYNC` is active for V_ATTIVO+V_FRONT ≤ Y < V_ATTIVO+V_FRONT+V_SYNC (601..604 by default).
- "Active" means the output level equals `SYNC_POL`.
- All outputs are registered and describe the same pixel as the X/Y currently output. Sync, visible and coordinate outputs have no relative skew.
- `INIZIO_QUADRO` is high for exactly the one CLK cycle after an enabled advance into (0,0).
- Shape detectors use out-of-range X/Y values freely. Downstream logic must gate with `VISIBILE`.

## Timing
- Reset values (held while `RST_N=0`):
  - X = H_TOT-1, Y = V_TOT-1
  - `VISIBILE=0`
  - `H_SYNC` and `V_SYNC` inactive (`!SYNC_POL`)
  - `INIZIO_QUADRO=0`
  - `QUADRO=0xFF`
- The first enabled edge after reset release lands on (0,0) with `INIZIO_QUADRO=1`. No partial frame is produced.
- Reset asserted mid-frame forces the reset values immediately (asynchronous). On release, timing restarts from the frame start as above.
- Latency: one enabled edge moves the outputs by one pixel. There is no pipeline delay between the counters and the decoded flags.
- At the simultaneous line and frame wrap (X=H_TOT-1, Y=V_TOT-1), a single enabled edge produces (0,0).

## Configuration
- `GENERATORE_VGA_QUADRO_EN` defined:
  - Adds the 8-bit `QUADRO` output, which increments (modulo 256) on each edge that asserts `INIZIO_QUADRO`.
  - From reset (0xFF), the first frame is 0.
- Not defined: the `QUADRO` port and its register do not exist. All other behaviour is identical.

## Structure
- The shared package `vga_pkg` holds:
  - the default timing constants for 800x600@60
  - the 11-bit coordinate width
  - the derived H_TOT/V_TOT functions
- The shape detectors import the same width constant.
- Sub-module `contatore_modulo`: parameterised modulo-N counter with enable, wrap-to-0, carry-out on wrap, and reset to N-1. It is instantiated twice; the vertical instance is enabled by the horizontal carry ANDed with `PIXEL_EN`.

## Test plan
- Reset, then release with `PIXEL_EN=1` → first edge gives X=0, Y=0, `VISIBILE=1`, `INIZIO_QUADRO=1`. The next edge gives X=1 and `INIZIO_QUADRO=0`.
- Run one line → `H_SYNC` goes active at X=840 and inactive at X=968. `VISIBILE` falls at X=800. X=1055 is followed by X=0 and Y=1.
- Run a full frame (663168 enabled cycles) → `V_SYNC` is active for Y=601..604 only. Y=627, X=1055 is followed by (0,0) with a single `INIZIO_QUADRO` pulse.
- Toggle `PIXEL_EN` low for 5 cycles at X=799 → all outputs hold at X=799 throughout. The next enabled edge gives X=800 and `VISIBILE=0`.
- Assert `RST_N` low at X=400, Y=300 → outputs take reset values asynchronously, before the next CLK edge. After release, the first enabled edge gives (0,0).
- With `GENERATORE_VGA_QUADRO_EN`, run 257 frames → `QUADRO` reads 0, 1, … 255, 0 across successive `INIZIO_QUADRO` pulses.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared raster constants: default 800x600@60 timing, coordinate width,
// and the helpers that derive the total line/frame lengths.
package vga_pkg;

    localparam int VGA_COORD_W  = 11;
    localparam int VGA_COORD_MAX = 2048;

    localparam int VGA_H_ATTIVO = 800;
    localparam int VGA_H_FRONT  = 40;
    localparam int VGA_H_SYNC   = 128;
    localparam int VGA_H_BACK   = 88;

    localparam int VGA_V_ATTIVO = 600;
    localparam int VGA_V_FRONT  = 1;
    localparam int VGA_V_SYNC   = 4;
    localparam int VGA_V_BACK   = 23;

    function automatic int vga_h_tot(input int attivo, input int front,
                                     input int sync, input int back);
        return attivo + front + sync + back;
    endfunction

    function automatic int vga_v_tot(input int attivo, input int front,
                                     input int sync, input int back);
        return attivo + front + sync + back;
    endfunction

endpackage

// File: rtl/generatore_vga_contatore.sv
// contatore_modulo: modulo-N counter with enable. Resets to N-1 so the
// first enabled edge lands on 0. Exposes the next value so the parent can
// register decoded flags in step with the count.
module contatore_modulo #(
    parameter int N = 2,
    parameter int W = 11
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         en_i,
    output logic [W-1:0] conteggio_o,
    output logic [W-1:0] prossimo_o,
    output logic         fine_o
);

    logic [W-1:0] conteggio_q;
    logic [W-1:0] conteggio_d;

    assign fine_o      = (conteggio_q == W'(N - 1));
    assign conteggio_o = conteggio_q;
    assign prossimo_o  = conteggio_d;

    // Next count: hold, increment, or wrap to 0 at terminal count.
    always_comb begin
        conteggio_d = conteggio_q;
        if (en_i) begin
            conteggio_d = fine_o ? '0 : conteggio_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            conteggio_q <= W'(N - 1);
        end else begin
            conteggio_q <= conteggio_d;
        end
    end

endmodule

// File: rtl/generatore_vga.sv
// generatore_vga: raster timing generator (coordinates, syncs, visible
// flag, frame-start pulse). Define GENERATORE_VGA_QUADRO_EN to add the
// 8-bit frame counter output QUADRO.
// The sync-width parameters are H_IMPULSO/V_IMPULSO because H_SYNC/V_SYNC
// are taken by the sync output ports.
module generatore_vga
    import vga_pkg::*;
#(
    parameter int H_ATTIVO  = VGA_H_ATTIVO,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_IMPULSO = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_ATTIVO  = VGA_V_ATTIVO,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_IMPULSO = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK,
    parameter bit SYNC_POL  = 1'b1
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   PIXEL_EN,
    output logic [VGA_COORD_W-1:0] X_CONTROLLO,
    output logic [VGA_COORD_W-1:0] Y_CONTROLLO,
    output logic                   H_SYNC,
    output logic                   V_SYNC,
    output logic                   VISIBILE,
    output logic                   INIZIO_QUADRO
`ifdef GENERATORE_VGA_QUADRO_EN
    ,
    output logic [7:0]             QUADRO
`endif
);

    localparam int H_TOT = vga_h_tot(H_ATTIVO, H_FRONT, H_IMPULSO, H_BACK);
    localparam int V_TOT = vga_v_tot(V_ATTIVO, V_FRONT, V_IMPULSO, V_BACK);
    localparam int CW    = VGA_COORD_W;

    if (H_TOT > VGA_COORD_MAX || V_TOT > VGA_COORD_MAX) begin : g_err_tot
        $error("generatore_vga: H_TOT/V_TOT exceed 11-bit coordinate range");
    end

    // Decode bounds one bit wider than the coordinates so a bound equal to
    // 2048 does not wrap.
    localparam logic [CW:0] H_VIS_FIN = (CW+1)'(H_ATTIVO);
    localparam logic [CW:0] H_SYN_INI = (CW+1)'(H_ATTIVO + H_FRONT);
    localparam logic [CW:0] H_SYN_FIN = (CW+1)'(H_ATTIVO + H_FRONT + H_IMPULSO);
    localparam logic [CW:0] V_VIS_FIN = (CW+1)'(V_ATTIVO);
    localparam logic [CW:0] V_SYN_INI = (CW+1)'(V_ATTIVO + V_FRONT);
    localparam logic [CW:0] V_SYN_FIN = (CW+1)'(V_ATTIVO + V_FRONT + V_IMPULSO);

    logic [CW-1:0] x_d;
    logic [CW-1:0] y_d;
    logic          h_fine;
    logic          v_fine;
    logic          v_en;

    logic          vis_q, vis_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          inizio_q, inizio_d;

    assign v_en = h_fine & PIXEL_EN;

    contatore_modulo #(.N(H_TOT), .W(CW)) u_cont_h (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .en_i        (PIXEL_EN),
        .conteggio_o (X_CONTROLLO),
        .prossimo_o  (x_d),
        .fine_o      (h_fine)
    );

    contatore_modulo #(.N(V_TOT), .W(CW)) u_cont_v (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .en_i        (v_en),
        .conteggio_o (Y_CONTROLLO),
        .prossimo_o  (y_d),
        .fine_o      (v_fine)
    );

    // Decode flags from the next coordinates so they register alongside them.
    always_comb begin
        logic [CW:0] xe;
        logic [CW:0] ye;
        xe       = {1'b0, x_d};
        ye       = {1'b0, y_d};
        vis_d    = (xe < H_VIS_FIN) && (ye < V_VIS_FIN);
        hs_d     = ((xe >= H_SYN_INI) && (xe < H_SYN_FIN)) ? SYNC_POL : ~SYNC_POL;
        vs_d     = ((ye >= V_SYN_INI) && (ye < V_SYN_FIN)) ? SYNC_POL : ~SYNC_POL;
        inizio_d = PIXEL_EN & h_fine & v_fine;
    end

    // Flag registers: update on enabled edges; the start pulse self-clears.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vis_q    <= 1'b0;
            hs_q     <= ~SYNC_POL;
            vs_q     <= ~SYNC_POL;
            inizio_q <= 1'b0;
        end else begin
            inizio_q <= inizio_d;
            if (PIXEL_EN) begin
                vis_q <= vis_d;
                hs_q  <= hs_d;
                vs_q  <= vs_d;
            end
        end
    end

    assign VISIBILE      = vis_q;
    assign H_SYNC        = hs_q;
    assign V_SYNC        = vs_q;
    assign INIZIO_QUADRO = inizio_q;

`ifdef GENERATORE_VGA_QUADRO_EN
    logic [7:0] quadro_q;
    logic [7:0] quadro_d;

    assign quadro_d = inizio_d ? quadro_q + 8'd1 : quadro_q;

    // Frame counter: starts at 0xFF so the first frame reads 0.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            quadro_q <= 8'hFF;
        end else begin
            quadro_q <= quadro_d;
        end
    end

    assign QUADRO = quadro_q;
`endif

endmodule

// File: tb/tb_generatore_vga.sv
// Scoreboard bench for generatore_vga, using a reduced raster so whole
// frames fit in a short run. The reference model tracks a linear pixel
// index and derives coordinates and flags arithmetically.
module tb_generatore_vga;
    import vga_pkg::*;

    localparam int HA = 16, HF = 3, HS = 5, HB = 4;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 3;
    localparam bit POL = 1'b0;
    localparam int HT  = HA + HF + HS + HB;
    localparam int VT  = VA + VF + VS + VB;
    localparam int TOT = HT * VT;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        PIXEL_EN = 1'b0;
    logic [10:0] X_CONTROLLO, Y_CONTROLLO;
    logic        H_SYNC, V_SYNC, VISIBILE, INIZIO_QUADRO;
`ifdef GENERATORE_VGA_QUADRO_EN
    logic [7:0]  QUADRO;
`endif

    generatore_vga #(
        .H_ATTIVO(HA), .H_FRONT(HF), .H_IMPULSO(HS), .H_BACK(HB),
        .V_ATTIVO(VA), .V_FRONT(VF), .V_IMPULSO(VS), .V_BACK(VB),
        .SYNC_POL(POL)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .PIXEL_EN      (PIXEL_EN),
        .X_CONTROLLO   (X_CONTROLLO),
        .Y_CONTROLLO   (Y_CONTROLLO),
        .H_SYNC        (H_SYNC),
        .V_SYNC        (V_SYNC),
        .VISIBILE      (VISIBILE),
        .INIZIO_QUADRO (INIZIO_QUADRO)
`ifdef GENERATORE_VGA_QUADRO_EN
        ,
        .QUADRO        (QUADRO)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        hs;
        logic        vs;
        logic        vis;
        logic        start;
        logic [7:0]  q;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state.
    int       idx;
    bit       start_m;
    bit [7:0] frm;

    function automatic exp_t expected();
        exp_t e;
        int x, y;
        x = idx % HT;
        y = idx / HT;
        e.x     = 11'(x);
        e.y     = 11'(y);
        e.vis   = (x < HA) && (y < VA);
        e.hs    = (x >= HA + HF && x < HA + HF + HS) ? POL : !POL;
        e.vs    = (y >= VA + VF && y < VA + VF + VS) ? POL : !POL;
        e.start = start_m;
        e.q     = frm;
        return e;
    endfunction

    task automatic reset_model();
        idx     = TOT - 1;
        start_m = 1'b0;
        frm     = 8'hFF;
    endtask

    task automatic step_model(input bit en);
        if (en) begin
            idx     = (idx + 1) % TOT;
            start_m = (idx == 0);
            if (start_m) frm = frm + 8'd1;
        end else begin
            start_m = 1'b0;
        end
    endtask

    // One clock: account for the edge just taken, then drive the next inputs
    // and queue what the outputs must show before the following edge.
    task automatic cycle(input bit en_next, input bit rn_next);
        @(posedge CLK);
        #1;
        if (RST_N) step_model(PIXEL_EN);
        RST_N = rn_next;
        if (!rn_next) reset_model();
        PIXEL_EN = en_next;
        sb.push_back(expected());
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Monitor: compare outputs against the oldest queued expectation.
    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("x",      int'(X_CONTROLLO),   int'(e.x));
            chk("y",      int'(Y_CONTROLLO),   int'(e.y));
            chk("h_sync", int'(H_SYNC),        int'(e.hs));
            chk("v_sync", int'(V_SYNC),        int'(e.vs));
            chk("visib",  int'(VISIBILE),      int'(e.vis));
            chk("inizio", int'(INIZIO_QUADRO), int'(e.start));
`ifdef GENERATORE_VGA_QUADRO_EN
            chk("quadro", int'(QUADRO),        int'(e.q));
`endif
        end
    end

    initial begin
        int hold_cnt;
        bit did_hold;
        bit did_rst;
        reset_model();
        RST_N    = 1'b0;
        PIXEL_EN = 1'b1;

        // Reset held with the enable high: outputs must stay at reset values.
        repeat (3) cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);

        // Continuous frames, with one 5-cycle enable hold at the last visible
        // column and one mid-frame asynchronous reset.
        hold_cnt = 0;
        did_hold = 1'b0;
        did_rst  = 1'b0;
        for (int i = 0; i < 3 * TOT + 20; i++) begin
            if (hold_cnt > 0) begin
                hold_cnt--;
                cycle(1'b0, 1'b1);
            end else if (!did_hold && i > TOT && (idx % HT) == HA - 1 && (idx / HT) == 2) begin
                did_hold = 1'b1;
                hold_cnt = 4;
                cycle(1'b0, 1'b1);
            end else if (!did_rst && i > 2 * TOT && idx == (VA / 2) * HT + HA / 2) begin
                did_rst = 1'b1;
                cycle(1'b1, 1'b0);
                cycle(1'b1, 1'b0);
            end else begin
                cycle(1'b1, 1'b1);
            end
        end

        // Randomized enable with occasional short resets.
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 499) != 0));
        end

        // Enough clean frames to wrap the 8-bit frame counter.
        for (int i = 0; i < 257 * TOT + 5; i++) begin
            cycle(1'b1, 1'b1);
        end

        begin
            int guard;
            guard = 0;
            while (sb.size() > 0 && guard < 10) begin
                @(negedge CLK);
                #1;
                guard++;
            end
            if (sb.size() > 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL drain: %0d expectations left, expected 0", sb.size());
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
